// File: rtl/circle_raster.sv
// circle_raster: per-scanline half-width lookup and per-pixel inside-circle flag
// for the video test-pattern generator.
module circle_raster #(
    parameter int XW = 9,
    parameter int YW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          line_start,
    input  logic [YW-1:0] vcount,
    input  logic [XW-1:0] hcount,
    input  logic          pix_stb,
    input  logic [XW-1:0] cx,
    input  logic [YW-1:0] cy,
    output logic [4:0]    lut_addr,
    input  logic [4:0]    lut_data,
    output logic          busy,
    output logic          pix_on
);
    typedef enum logic [1:0] {IDLE, CALC, LOOKUP, RUN} state_t;
    state_t        state;
    logic [YW-1:0] vlat;
    logic [4:0]    hw;
    logic          line_ok;
    logic [YW:0]   vx, cyx, dy;
    logic [XW:0]   hx, cxx, dx;
    // Distances are taken one bit wider so the subtraction never wraps.
    always_comb begin
        vx  = {1'b0, vlat};
        cyx = {1'b0, cy};
        hx  = {1'b0, hcount};
        cxx = {1'b0, cx};
        dy  = vx >= cyx ? vx - cyx : cyx - vx;
        dx  = hx >= cxx ? hx - cxx : cxx - hx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vlat     <= '0;
            hw       <= '0;
            line_ok  <= 1'b0;
            lut_addr <= 5'h1F;
            busy     <= 1'b0;
            pix_on   <= 1'b0;
        end else if (!enable) begin
            state    <= IDLE;
            line_ok  <= 1'b0;
            lut_addr <= 5'h1F;
            busy     <= 1'b0;
            pix_on   <= 1'b0;
        end else begin
            if (pix_stb)
                pix_on <= (state == RUN) && line_ok && (dx < (XW+1)'(hw));
            if (line_start) begin
                state <= CALC;
                vlat  <= vcount;
                busy  <= 1'b1;
            end else begin
                case (state)
                    CALC: begin
                        line_ok  <= dy <= (YW+1)'(30);
                        lut_addr <= dy <= (YW+1)'(30) ? 5'd30 - dy[4:0] : 5'h1F;
                        state    <= LOOKUP;
                    end
                    LOOKUP: begin
                        hw    <= line_ok ? lut_data : 5'd0;
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_circle_raster.sv
// tb_circle_raster: scoreboard bench for circle_raster with a radius-29 quarter-circle LUT model.
module tb_circle_raster;
    logic       clk = 0, rst_n = 0, enable = 0, line_start = 0, pix_stb = 0;
    logic [8:0] vcount = 0, hcount = 0, cx = 200, cy = 100;
    logic [4:0] lut_addr, lut_data;
    logic       busy, pix_on;
    int         total = 0, bad = 0;
    int         hw_m = 0;
    bit         run_m = 0;
    logic [31:0] q[$];

    circle_raster #(.XW(9), .YW(9)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .line_start(line_start),
        .vcount(vcount), .hcount(hcount), .pix_stb(pix_stb), .cx(cx), .cy(cy),
        .lut_addr(lut_addr), .lut_data(lut_data), .busy(busy), .pix_on(pix_on)
    );

    always #5 clk = ~clk;

    function automatic int lut_fn(input int a);
        int d = 30 - a;
        int w = 0;
        if (a == 31) return 31;
        while ((w + 1) * (w + 1) <= 841 - d * d) w++;
        return w;
    endfunction

    always_comb lut_data = 5'(lut_fn(int'(lut_addr)));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && pix_stb) begin
            logic [31:0] e;
            #1;
            e = q.size() != 0 ? q.pop_front() : 32'd2;
            chk("pix_on", {31'd0, pix_on}, e);
        end
    end

    task automatic start_line(input int v);
        int dy = v > int'(cy) ? v - int'(cy) : int'(cy) - v;
        int ea = dy <= 30 ? 30 - dy : 31;
        @(negedge clk); line_start = 1; vcount = 9'(v);
        @(negedge clk); line_start = 0;
        chk("busy_calc", {31'd0, busy}, 1);
        @(negedge clk);
        chk("lut_addr", {27'd0, lut_addr}, ea);
        chk("busy_lookup", {31'd0, busy}, 1);
        @(negedge clk);
        chk("busy_run", {31'd0, busy}, 0);
        hw_m = dy <= 30 ? lut_fn(ea) : 0;
        run_m = 1;
    endtask

    task automatic scan(input int lo, input int hi);
        for (int h = lo; h <= hi; h++) begin
            int dx;
            @(negedge clk);
            pix_stb = 1; hcount = 9'(h);
            dx = h > int'(cx) ? h - int'(cx) : int'(cx) - h;
            q.push_back(run_m && dx < hw_m ? 32'd1 : 32'd0);
        end
        @(negedge clk); pix_stb = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_addr", {27'd0, lut_addr}, 31);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pix", {31'd0, pix_on}, 0);
        @(negedge clk); rst_n = 1; enable = 1;
        // centre row, edges, symmetric rows, and the zero/out-of-range rows
        start_line(100); scan(170, 230);
        start_line(90);  scan(172, 176); scan(224, 228);
        start_line(110); scan(172, 176); scan(224, 228);
        start_line(130); scan(198, 202);
        start_line(70);  scan(199, 201);
        start_line(131); scan(199, 201);
        // back-to-back line_start: second vcount wins, busy held throughout
        @(negedge clk); line_start = 1; vcount = 100;
        @(negedge clk); vcount = 90;
        chk("b2b_busy1", {31'd0, busy}, 1);
        @(negedge clk); line_start = 0;
        chk("b2b_busy2", {31'd0, busy}, 1);
        @(negedge clk);
        chk("b2b_addr", {27'd0, lut_addr}, 20);
        @(negedge clk);
        chk("b2b_busy3", {31'd0, busy}, 0);
        hw_m = 27; run_m = 1;
        scan(172, 175); scan(225, 228);
        // enable drop mid-line
        start_line(100); scan(188, 189);
        @(negedge clk); pix_stb = 1; hcount = 190; enable = 0;
        q.push_back(0); run_m = 0;
        @(negedge clk); pix_stb = 0;
        chk("dis_addr", {27'd0, lut_addr}, 31);
        chk("dis_busy", {31'd0, busy}, 0);
        @(negedge clk); enable = 1;
        scan(195, 196);
        // asynchronous reset mid-line
        start_line(100); scan(200, 200);
        @(negedge clk); rst_n = 0; #1;
        chk("arst_pix", {31'd0, pix_on}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_addr", {27'd0, lut_addr}, 31);
        run_m = 0;
        @(negedge clk); rst_n = 1;
        scan(200, 201);
        // centre near column 0 and far columns near the top of the range
        @(negedge clk); enable = 0; cx = 5;
        @(negedge clk); enable = 1;
        start_line(100); scan(0, 40); scan(500, 511);
        repeat (3) @(negedge clk);
        chk("q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/circle_raster.md
Name: circle_raster

Overview:
- Consumer side of the quarter-circle half-width lookup table used by the test/service video generator.
- At each scanline start, computes the vertical distance to the circle centre, addresses the external 5-bit-in/5-bit-out half-width LUT, and latches the returned half-width.
- During the visible line, flags every pixel whose horizontal distance from centre is inside that half-width.
- Sits between the video timing counters and the pixel colour mux.

Parameters:
XW, 9, width of hcount and cx
YW, 9, width of vcount and cy

Ports:
clk  in  1  pixel-domain clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  circle drawing enable
line_start  in  1  one-cycle pulse per scanline, at least 3 clk before the first pix_stb of the line
vcount  in  YW  current line number, sampled on line_start
hcount  in  XW  current pixel column, sampled on pix_stb
pix_stb  in  1  pixel enable
cx  in  XW  circle centre column, static while enable=1
cy  in  YW  circle centre line, static while enable=1
lut_addr  out  5  address to the half-width LUT, registered
lut_data  in  5  half-width from LUT, combinational on lut_addr
busy  out  1  high while a line lookup is in progress
pix_on  out  1  pixel lies inside circle, registered

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n.
- Reset values: lut_addr=5'h1F, busy=0, pix_on=0, FSM=IDLE, internal hw=0, line_ok=0.
- FSM states: IDLE, CALC, LOOKUP, RUN.
- IDLE -> CALC on line_start & enable.
- CALC (1 clk):
  - dy = |vcount_latched - cy|, computed at YW+1 bits with no wrap.
  - If dy<=30: lut_addr <= 5'd30 - dy, line_ok <= 1.
  - Else: lut_addr <= 5'h1F, line_ok <= 0.
  - Next state LOOKUP.
- LOOKUP (1 clk): hw <= line_ok ? lut_data : 0. Next state RUN.
- RUN: on each pix_stb:
  - dx = |hcount - cx| at XW+1 bits.
  - pix_on <= line_ok & (dx < hw).
  - Latency is one clk from pix_stb.
  - pix_on holds its value between strobes.
- busy=1 in CALC and LOOKUP.
- Exit from RUN:
  - RUN -> CALC on the next line_start (vcount re-latched).
  - RUN -> IDLE when enable drops.
- line_start arriving while in CALC or LOOKUP restarts CALC with the new vcount; no stale hw is used.
- pix_stb outside RUN: pix_on <= 0.
- enable=0 in any state: next clk FSM=IDLE, pix_on=0, lut_addr=5'h1F, line_ok=0.
- rst_n low mid-line: all state returns to reset values immediately (asynchronous); the first line after release draws nothing until a line_start arrives.
- Address 5'h1F is never issued for a valid line.
- Address 0 (the circle's top/bottom row) returns width 0, so no pixels are drawn on that row.
- Horizontal extent: dx < hw strictly, giving 2*hw-1 pixels centred on cx.

Test Plan:
1. cx=200, cy=100, enable=1; line_start with vcount=100 -> lut_addr=30, hw=29; pix_on=1 exactly for hcount 172..228 (57 px), 0 at 171 and 229.
2. vcount=90 -> dy=10, lut_addr=20, hw=27 -> pix_on for hcount 174..226. vcount=110 -> same result (symmetry).
3. vcount=130 and vcount=70 -> lut_addr=0, hw=0, no pix_on on that line. vcount=131 -> line_ok=0, lut_addr=5'h1F, no pix_on.
4. Second line_start one clk after the first (vcount 100 then 90) -> busy stays high; the latched hw is 27, not 29.
5. enable dropped mid-RUN at hcount=190 -> pix_on=0 from the next clk, FSM IDLE. rst_n pulsed low mid-line -> pix_on, busy and lut_addr immediately at reset values.
6. Wide-coordinate check: cx=5, hcount=0..40 with hw=29 -> pix_on for hcount 0..33, and no false hits from subtraction wrap near hcount=511.
